// File: rtl/tlu_emulator.sv
// Trigger Logic Unit emulator: local/periodic trigger generation driving TLU_TRIGGER/TLU_RESET
// towards a DAQ TLU receiver, with pulse, handshake and handshake+serial-ID modes.
module tlu_emulator #(
  parameter int unsigned TRIG_ID_WIDTH = 15,
  parameter int unsigned PERIOD_WIDTH  = 16,
  parameter int unsigned TIMEOUT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned RESET_LENGTH  = 4
) (
  input  logic                     SYS_CLK,
  input  logic                     SYS_RST_N,
  input  logic                     ENABLE,
  input  logic [1:0]               MODE,
  input  logic                     START_TRIGGER,
  input  logic [PERIOD_WIDTH-1:0]  TRIG_PERIOD,
  input  logic [7:0]               TRIG_LENGTH,
  input  logic [TIMEOUT_WIDTH-1:0] BUSY_TIMEOUT,
  input  logic                     CLEAR_ID,
  input  logic                     TLU_CLOCK,
  input  logic                     TLU_BUSY,
  output logic                     TLU_TRIGGER,
  output logic                     TLU_RESET,
  output logic [TRIG_ID_WIDTH-1:0] TRIG_ID,
  output logic [CNT_WIDTH-1:0]     ACCEPTED_CNT,
  output logic [CNT_WIDTH-1:0]     VETOED_CNT,
  output logic [CNT_WIDTH-1:0]     TIMEOUT_CNT,
  output logic                     IDLE
);

  localparam int unsigned RST_CW = (RESET_LENGTH < 2) ? 1 : $clog2(RESET_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_TRIG, S_READ} state_t;

  state_t                     r_state;
  logic                       r_clk_meta, r_clk_s, r_clk_s_d;
  logic                       r_busy_meta, r_busy_s;
  logic [PERIOD_WIDTH-1:0]    r_per_cnt;
  logic [TRIG_ID_WIDTH-1:0]   r_next_id;
  logic [TRIG_ID_WIDTH-1:0]   r_trig_id;
  logic [TRIG_ID_WIDTH:0]     r_sr;
  logic                       r_mode_id;
  logic [7:0]                 r_plen;
  logic [7:0]                 r_pcnt;
  logic [TIMEOUT_WIDTH-1:0]   r_wait;
  logic                       r_trig;
  logic                       r_idle;
  logic                       r_tlu_reset;
  logic [RST_CW-1:0]          r_rst_cnt;
  logic [CNT_WIDTH-1:0]       r_acc_cnt, r_veto_cnt, r_tmo_cnt;

  logic                       w_clk_rise;
  logic                       w_per_on, w_tick, w_req, w_accept, w_veto, w_timeout;
  logic [7:0]                 w_pulse_len;

  assign w_clk_rise  = r_clk_s & ~r_clk_s_d;
  assign w_per_on    = ENABLE && (TRIG_PERIOD != '0);
  assign w_tick      = w_per_on && (r_per_cnt >= TRIG_PERIOD);
  assign w_req       = START_TRIGGER | w_tick;
  assign w_accept    = w_req & ENABLE & (r_state == S_IDLE) & ~r_tlu_reset
                       & ~(r_clk_s & (MODE != 2'd0));
  assign w_veto      = w_req & ENABLE & ~w_accept;
  assign w_pulse_len = (TRIG_LENGTH == 8'd0) ? 8'd1 : TRIG_LENGTH;
  assign w_timeout   = (r_state == S_TRIG) && !r_busy_s && (BUSY_TIMEOUT != '0)
                       && (r_wait == BUSY_TIMEOUT - 1'b1);

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_clk_meta  <= 1'b0;
      r_clk_s     <= 1'b0;
      r_clk_s_d   <= 1'b0;
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
    end else begin
      r_clk_meta  <= TLU_CLOCK;
      r_clk_s     <= r_clk_meta;
      r_clk_s_d   <= r_clk_s;
      r_busy_meta <= TLU_BUSY;
      r_busy_s    <= r_busy_meta;
    end
  end

  // Period counter runs 1..TRIG_PERIOD; >= also recovers if the period is lowered mid-count.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_per_cnt <= '0;
    end else if (!w_per_on) begin
      r_per_cnt <= '0;
    end else if (w_tick) begin
      r_per_cnt <= PERIOD_WIDTH'(1);
    end else begin
      r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_next_id   <= '0;
      r_trig_id   <= '0;
      r_tlu_reset <= 1'b0;
      r_rst_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_trig_id <= r_next_id;
      end
      if (CLEAR_ID) begin
        r_next_id <= '0;
      end else if (w_accept) begin
        r_next_id <= r_next_id + 1'b1;
      end
      if (CLEAR_ID) begin
        r_tlu_reset <= 1'b1;
        r_rst_cnt   <= RST_CW'(RESET_LENGTH - 1);
      end else if (r_rst_cnt != '0) begin
        r_rst_cnt <= r_rst_cnt - 1'b1;
      end else begin
        r_tlu_reset <= 1'b0;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_acc_cnt  <= '0;
      r_veto_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      if (w_accept && (r_acc_cnt != '1)) begin
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (w_veto && (r_veto_cnt != '1)) begin
        r_veto_cnt <= r_veto_cnt + 1'b1;
      end
      if (w_timeout && (r_tmo_cnt != '1)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_mode_id <= 1'b0;
      r_plen    <= 8'd1;
      r_pcnt    <= '0;
      r_wait    <= '0;
      r_trig    <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode_id <= MODE[1];
            r_plen    <= w_pulse_len;
            r_pcnt    <= '0;
            r_wait    <= '0;
            r_trig    <= 1'b1;
            r_idle    <= 1'b0;
            if (MODE == 2'd0) begin
              r_state <= S_PULSE;
            end else begin
              r_state <= S_TRIG;
              if (MODE[1]) begin
                r_sr <= {r_next_id, 1'b0};
              end
            end
          end
        end
        S_PULSE: begin
          if (r_pcnt == r_plen - 8'd1) begin
            r_state <= S_IDLE;
            r_trig  <= 1'b0;
            r_idle  <= 1'b1;
          end else begin
            r_pcnt <= r_pcnt + 8'd1;
          end
        end
        S_TRIG: begin
          if (r_busy_s) begin
            r_state <= S_READ;
            r_trig  <= r_mode_id ? r_sr[0] : 1'b0;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_trig  <= 1'b0;
            r_idle  <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_READ: begin
          if (!r_busy_s) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_trig  <= 1'b0;
            r_idle  <= 1'b1;
          end else if (w_clk_rise) begin
            // Register the bit that becomes SR[0] after this shift, so the line tracks SR[0].
            r_sr   <= {1'b0, r_sr[TRIG_ID_WIDTH:1]};
            r_trig <= r_mode_id ? r_sr[1] : 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_trig  <= 1'b0;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign TLU_TRIGGER  = r_trig;
  assign TLU_RESET    = r_tlu_reset;
  assign TRIG_ID      = r_trig_id;
  assign ACCEPTED_CNT = r_acc_cnt;
  assign VETOED_CNT   = r_veto_cnt;
  assign TIMEOUT_CNT  = r_tmo_cnt;
  assign IDLE         = r_idle;

endmodule

// File: doc/tlu_emulator.md
# tlu_emulator

Parametrised, synthesisable Trigger Logic Unit emulator for hardware-in-the-loop and simulation benches. It generates triggers from an external request or an internal periodic generator and drives the TLU_TRIGGER/TLU_RESET lines towards the DAQ's TLU receiver. It supports three handshake modes (simple pulse, handshake, handshake with serial trigger-ID readout), a busy timeout, and status counters. It sits on the bench side of the DAQ's TLU port and replaces fixed-width, handshake-only trigger models.

## Interface
- TRIG_ID_WIDTH, 15, width of trigger ID shifted out in mode 2
- PERIOD_WIDTH, 16, width of TRIG_PERIOD
- TIMEOUT_WIDTH, 16, width of BUSY_TIMEOUT
- CNT_WIDTH, 16, width of status counters
- RESET_LENGTH, 4, TLU_RESET pulse length in cycles (≥1)
- SYS_CLK  in  1  single clock, all logic on rising edge
- SYS_RST_N  in  1  asynchronous, active-low reset
- ENABLE  in  1  gates acceptance of new requests
- MODE  in  2  0 simple pulse, 1 handshake, 2 handshake+ID, 3 same as 2; sampled only at acceptance
- START_TRIGGER  in  1  one-cycle trigger request
- TRIG_PERIOD  in  PERIOD_WIDTH  internal request period in cycles; 0 disables
- TRIG_LENGTH  in  8  mode-0 pulse length; 0 treated as 1
- BUSY_TIMEOUT  in  TIMEOUT_WIDTH  cycles to wait for BUSY in TRIG; 0 disables
- CLEAR_ID  in  1  one-cycle request: zero the ID and pulse TLU_RESET
- TLU_CLOCK  in  1  asynchronous, from DAQ
- TLU_BUSY  in  1  asynchronous, from DAQ
- TLU_TRIGGER  out  1  registered trigger/data line
- TLU_RESET  out  1  registered reset line
- TRIG_ID  out  TRIG_ID_WIDTH  ID of most recently accepted trigger
- ACCEPTED_CNT, VETOED_CNT, TIMEOUT_CNT  out  CNT_WIDTH each  saturating status counters
- IDLE  out  1  high in IDLE state

## Operation
- TLU_CLOCK and TLU_BUSY pass through 2-FF synchronisers (clk_s, busy_s). A rising edge of clk_s is detected with one further register.
- Request: START_TRIGGER or periodic tick. Both together count as one request.
- Periodic generator counts 1..TRIG_PERIOD and ticks on reaching TRIG_PERIOD. It is held at 0 while ENABLE=0 or TRIG_PERIOD=0.
- Accept condition: request & ENABLE & state==IDLE & !TLU_RESET & !(clk_s & mode≠0).
- On accept:
  - TRIG_ID<=next_id; next_id<=next_id+1, wrapping modulo 2^TRIG_ID_WIDTH.
  - ACCEPTED_CNT+1.
  - MODE is latched.
  - In mode≥2, shift register SR (TRIG_ID_WIDTH+1 bits) <= {next_id,1'b0}.
- Any request not accepted while ENABLE=1 increments VETOED_CNT.
- FSM states:
  - IDLE: on accept -> PULSE (mode 0) or TRIG (mode 1..3).
  - PULSE: TLU_TRIGGER=1 for max(TRIG_LENGTH,1) cycles, then -> IDLE. TLU_BUSY is ignored.
  - TRIG: TLU_TRIGGER=1.
    - busy_s=1 -> READ.
    - Wait counter reaches BUSY_TIMEOUT (≠0) -> IDLE with TIMEOUT_CNT+1.
  - READ: TLU_TRIGGER = SR[0] in mode≥2, 0 in mode 1.
    - Each clk_s rising edge shifts SR right, filling with 0.
    - busy_s=0 -> IDLE and clears SR.
- ID bit order in mode 2: the first TLU_CLOCK edge after BUSY exposes ID[0] (LSB first). After TRIG_ID_WIDTH edges, TLU_TRIGGER stays 0.
- CLEAR_ID is honoured in any state:
  - next_id<=0.
  - TLU_RESET high for RESET_LENGTH cycles.
  - A CLEAR_ID during the pulse restarts the pulse.
  - TRIG_ID and an in-flight transaction are unaffected.
- ENABLE falling mid-transaction: the transaction completes normally. Only new acceptance is blocked.
- Counters saturate at all-ones. They are cleared only by reset.

## Timing
- Reset (SYS_RST_N=0, async) values:
  - TLU_TRIGGER=0, TLU_RESET=0, TRIG_ID=0, next_id=0.
  - All counters 0, IDLE=1, state IDLE, SR=0, synchronisers 0.
- Accept latency: request sampled at edge t; TLU_TRIGGER=1 and IDLE=0 after edge t (visible from cycle t+1).
- Busy response: TLU_BUSY rising is seen in busy_s 2 cycles later. The state changes to READ and TLU_TRIGGER drops (mode 1) or becomes SR[0]=0 (mode 2) one cycle after that.
- Timeout: TRIG state is left exactly BUSY_TIMEOUT cycles after entry.
- Mode 0: TLU_TRIGGER high exactly TRIG_LENGTH cycles. IDLE returns the cycle after the pulse ends; back-to-back accepts are possible with a 1-cycle gap.
- Shift: TLU_TRIGGER changes one cycle after the clk_s rising edge is detected (3 SYS_CLK after the TLU_CLOCK edge). The DAQ samples on the falling TLU_CLOCK edge.
- Release: IDLE returns one cycle after busy_s falls.
- Reset asserted mid-transaction: all outputs go to reset values immediately.

## Test plan
- Mode 1, START_TRIGGER at cycle 10, DAQ raises BUSY 5 cycles later, drops after 20 -> TLU_TRIGGER high until busy_s seen, IDLE returns; ACCEPTED_CNT=1, TRIG_ID=0.
- Mode 2, three triggers, DAQ clocks 15 TLU_CLOCK edges each -> decoded IDs 0,1,2 (LSB first); TLU_TRIGGER=0 on any extra edges.
- Mode 0, TRIG_LENGTH=0 then 5, TRIG_PERIOD=20 for 200 cycles -> 10 pulses of width 5 at a 20-cycle period, TLU_BUSY ignored; first pulse has width 1 when TRIG_LENGTH=0.
- Mode 1, BUSY_TIMEOUT=50, TLU_BUSY held low -> TLU_TRIGGER high for exactly 50 cycles; TIMEOUT_CNT=1; next request is accepted.
- START_TRIGGER pulsed every cycle during a handshake, plus a request while TLU_CLOCK=1 in mode 2 -> VETOED_CNT equals the request count minus accepts; no extra triggers.
- Set next_id to 2^15-1 via triggers, then CLEAR_ID mid-READ -> TLU_RESET high 4 cycles; current transaction unaffected; next trigger ID=0. Separately, a wrap from 32767 gives 0. Async reset mid-READ -> all reset values immediately.
